program_loader: RTL



---
 rtl/loader_pkg.sv | 7 +
 rtl/loader_addr_counter.sv | 35 +++
 rtl/program_loader.sv | 93 +++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, word width and default base address
// for the program loader and the processor PC reset value.
package loader_pkg;
    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 16'h0000;
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_e;
endpackage

// File: rtl/loader_addr_counter.sv
// loader_addr_counter: loadable RAM write address and accepted-word counter,
// with 16-bit wrap on the address and an image-size limit compare.
module loader_addr_counter
    import loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              inc_i,
    output logic [WORD_W-1:0] addr_o,
    output logic [WORD_W-1:0] count_o,
    output logic              at_limit_o
);
    localparam logic [WORD_W-1:0] LIMIT = WORD_W'(MAX_WORDS - 1);
    logic [WORD_W-1:0] addr_q, addr_d, count_q, count_d;
    always_comb begin
        addr_d  = load_i ? BASE_ADDR : inc_i ? addr_q + 16'd1 : addr_q;
        count_d = load_i ? '0 : inc_i ? count_q + 16'd1 : count_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= BASE_ADDR;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end
    assign addr_o     = addr_q;
    assign count_o    = count_q;
    assign at_limit_o = count_q == LIMIT;
endmodule

// File: rtl/program_loader.sv
// program_loader: streams host words into the RAM write port and holds the CPU
// in reset until an image is loaded. LOADER_CHECKSUM_EN adds a trailing checksum beat.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int                MAX_WORDS = 1024,
    parameter int                DATA_W    = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_word,
    input  logic              host_last,
    output logic              host_ready,
    output logic              ram_wrEN,
    output logic [WORD_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_write_value,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [WORD_W-1:0] word_count
);
`ifdef LOADER_CHECKSUM_EN
    localparam state_e LAST_NEXT = CHECK;
`else
    localparam state_e LAST_NEXT = DONE;
`endif
    state_e            state_q, state_d;
    logic              accept, data_beat, ctr_load, at_limit;
    logic [WORD_W-1:0] addr, wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_val_q, wr_val_d;
    logic              wr_en_q, wr_en_d, hold_q, hold_d, done_q, done_d, err_q, err_d;
    assign host_ready = state_q == LOAD || state_q == CHECK;
    assign accept     = host_valid & host_ready;
    assign data_beat  = accept & (state_q == LOAD);
    assign ctr_load   = start & ~host_ready;
    loader_addr_counter #(.BASE_ADDR(BASE_ADDR), .MAX_WORDS(MAX_WORDS)) u_ctr (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ctr_load),
        .inc_i     (data_beat),
        .addr_o    (addr),
        .count_o   (word_count),
        .at_limit_o(at_limit)
    );
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    assign sum_d = ctr_load ? '0 : data_beat ? sum_q + host_word : sum_q;
    always_ff @(posedge clk) sum_q <= reset ? '0 : sum_d;
`endif
    always_comb begin
        state_d = state_q;
        if (ctr_load) state_d = LOAD;
        else if (data_beat) state_d = host_last ? LAST_NEXT : at_limit ? ERR : LOAD;
`ifdef LOADER_CHECKSUM_EN
        else if (accept) state_d = host_word == sum_q ? DONE : ERR;
`endif
        wr_en_d   = data_beat;
        wr_addr_d = data_beat ? addr : wr_addr_q;
        wr_val_d  = data_beat ? host_word : wr_val_q;
        // Release only once DONE is already registered, so the final write pulse precedes it.
        done_d    = state_q == DONE && state_d == DONE;
        hold_d    = ~done_d;
        err_d     = state_d == ERR;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE_ADDR;
            wr_val_q  <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_val_q  <= wr_val_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
    assign ram_wrEN          = wr_en_q;
    assign ram_write_address = wr_addr_q;
    assign ram_write_value   = wr_val_q;
    assign cpu_hold          = hold_q;
    assign load_done         = done_q;
    assign load_error        = err_q;
endmodule
